// File: rtl/seq_detector_param_pkg.sv
// -----------------------------------------------------------------------------
// seq_detector_param_pkg
//   Shared types and helpers for the parametrised serial pattern detector.
//   - det_state_e : detector FSM states
//   - LEN_W       : pattern-length field width for the default MAX_LEN
//   - len_bits()  : pattern-length field width for an arbitrary MAX_LEN
//   - len_legal() : range check applied when a new config is loaded
// -----------------------------------------------------------------------------
package seq_detector_param_pkg;

    localparam int MAX_LEN_DFLT = 8;
    localparam int LEN_W        = $clog2(MAX_LEN_DFLT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no usable config loaded
        S_FILL = 2'd1,   // window not yet holding pat_len fresh bits
        S_HUNT = 2'd2    // window full, compare on every sampled bit
    } det_state_e;

    function automatic int len_bits(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic len_legal(input int len, input int max_len);
        return (len >= 2) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
//   Serial stream, config and status bundle of the pattern detector.
//   master : drives en/x/load/pat/pat_len/overlap/clr_cnt, sees status
//   slave  : the detector; drives y/users_count/cnt_sat/cfg_err
// -----------------------------------------------------------------------------
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 10
);
    localparam int LW = seq_detector_param_pkg::len_bits(MAX_LEN);

    logic               en;
    logic               x;
    logic               load;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      pat_len;
    logic               overlap;
    logic               clr_cnt;
    logic               y;
    logic [CNT_W-1:0]   users_count;
    logic               cnt_sat;
    logic               cfg_err;

    modport master (
        output en, x, load, pat, pat_len, overlap, clr_cnt,
        input  y, users_count, cnt_sat, cfg_err
    );

    modport slave (
        input  en, x, load, pat, pat_len, overlap, clr_cnt,
        output y, users_count, cnt_sat, cfg_err
    );
endinterface

// File: rtl/seq_detector_param_hit_counter.sv
// -----------------------------------------------------------------------------
// seq_detector_param_hit_counter
//   Hit event counter, saturating or wrapping.
//   clk, rst   : clock, async active-low reset
//   inc_i      : count one hit
//   clr_i      : synchronous clear, wins over inc_i
//   count_o    : current count
//   sat_o      : count is all-ones (only when SATURATE=1)
// -----------------------------------------------------------------------------
module seq_detector_param_hit_counter #(
    parameter int CNT_W    = 10,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;

    assign full = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            // In wrap mode the natural +1 overflow gives the roll to zero.
            if (!(SATURATE && full)) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;
    assign sat_o   = SATURATE && full;
endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Run-time programmable serial bit-pattern detector with hit counter.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : seq_detector_param_if.slave
//          en/x     serial input with sample enable
//          load     latch pat/pat_len/overlap and restart detection
//          clr_cnt  clear users_count
//          y        registered 1-cycle hit pulse
//          users_count/cnt_sat/cfg_err status
//   Pattern bit [pat_len-1] is the first received bit; bit 0 the last, so
//   the window shifts new bits in at bit 0 and compares its low pat_len bits.
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter int MAX_LEN  = MAX_LEN_DFLT,
    parameter int CNT_W    = 10,
    parameter bit SATURATE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    seq_detector_param_if.slave bus
);
    localparam int LW = len_bits(MAX_LEN);

    det_state_e         state_q, state_d;
    logic [MAX_LEN-1:0] win_q, win_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic               err_q, err_d;
    logic               y_q;
    logic               hit;
    logic               legal;
    logic               match;
    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;

    assign legal   = len_legal(int'(bus.pat_len), MAX_LEN);
    assign shifted = {win_q[MAX_LEN-2:0], bus.x};

    // Only the low pat_len bits of window and pattern take part in a match.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
    end

    assign match = (((shifted ^ pat_q) & mask) == '0);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = err_q;
        hit     = 1'b0;
        if (bus.load) begin
            // A load discards whatever bit arrives with it.
            pat_d  = bus.pat;
            len_d  = bus.pat_len;
            ovl_d  = bus.overlap;
            win_d  = '0;
            fill_d = '0;
            if (legal) begin
                state_d = S_FILL;
                err_d   = 1'b0;
            end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
        end else if (bus.en) begin
            unique case (state_q)
                S_IDLE: ;
                S_FILL: begin
                    win_d = shifted;
                    // The bit completing the window is already compared.
                    if (fill_q == len_q - LW'(1)) begin
                        hit     = match;
                        state_d = S_HUNT;
                    end else begin
                        fill_d = fill_q + LW'(1);
                    end
                end
                S_HUNT: begin
                    win_d = shifted;
                    hit   = match;
                end
                default: state_d = S_IDLE;
            endcase
            // Non-overlapping mode: next match needs pat_len fresh bits.
            if (hit && !ovl_q) begin
                state_d = S_FILL;
                fill_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            err_q   <= err_d;
            y_q     <= hit;
        end
    end

    seq_detector_param_hit_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (hit),
        .clr_i   (bus.clr_cnt),
        .count_o (bus.users_count),
        .sat_o   (bus.cnt_sat)
    );

    assign bus.y       = y_q;
    assign bus.cfg_err = err_q;
endmodule
